id_fetch_control: RTL and testbench

Decode-side counterpart of the fetch stage. Holds the IF/ID pipeline register, resolves `beq`/`bne`/`j` in ID, and returns `branch_address`, `jump_address`, `branch_taken`, `jump` and the PC enable `en` to the fetch stage. A small stall counter detects load-use and branch-operand hazards, freezes fetch and IF/ID, and injects bubbles into ID/EX.

---
 rtl/id_fetch_control.sv | 83 ++++++++
 tb/tb_id_fetch_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_fetch_control.sv
// id_fetch_control: IF/ID register, ID-stage branch/jump resolution and hazard stall control
module id_fetch_control #(
    parameter int PC_W          = 10,
    parameter int LOAD_BR_STALL = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [31:0]     instr,
    input  logic [31:0]     rs_data,
    input  logic [31:0]     rt_data,
    input  logic            ex_mem_read,
    input  logic            ex_reg_write,
    input  logic [4:0]      ex_write_reg,
    output logic            en,
    output logic [PC_W-1:0] branch_address,
    output logic [PC_W-1:0] jump_address,
    output logic            branch_taken,
    output logic            jump,
    output logic [PC_W-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic            id_valid,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic            id_bubble
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [1:0]      scnt_q, scnt_d;
    logic            is_beq, is_bne, is_j, is_br, uses_rt;
    logic            ld_hit, alu_hit, hazard, stall, redirect;
    logic [9:0]      imm;

    // decode, hazard detection and redirect; scnt counts stall cycles still owed after the current one
    always_comb begin
        is_beq         = instr_q[31:26] == 6'h04;
        is_bne         = instr_q[31:26] == 6'h05;
        is_j           = instr_q[31:26] == 6'h02;
        is_br          = is_beq | is_bne;
        uses_rt        = instr_q[31:26] == 6'h00 || is_br;
        ld_hit         = ex_mem_read && ex_write_reg != 5'd0 &&
                         (ex_write_reg == instr_q[25:21] || (uses_rt && ex_write_reg == instr_q[20:16]));
        alu_hit        = ex_reg_write && ex_write_reg != 5'd0 && is_br &&
                         (ex_write_reg == instr_q[25:21] || ex_write_reg == instr_q[20:16]);
        hazard         = scnt_q == 2'd0 && valid_q && (ld_hit || alu_hit);
        stall          = scnt_q != 2'd0 || hazard;
        imm            = {instr_q[7:0], 2'b00};
        branch_address = pc_q + PC_W'(imm);
        jump_address   = PC_W'(imm);
        branch_taken   = valid_q && !stall && ((is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data));
        jump           = valid_q && !stall && is_j;
        redirect       = branch_taken || jump;
        en             = !stall;
        id_bubble      = stall;
        scnt_d         = scnt_q != 2'd0 ? scnt_q - 2'd1 :
                         hazard && ld_hit && is_br ? 2'(LOAD_BR_STALL - 1) : 2'd0;
        pc_d           = stall ? pc_q : pc_plus4;
        instr_d        = stall ? instr_q : redirect ? 32'd0 : instr;
        valid_d        = stall ? valid_q : !redirect;
    end

    // IF/ID pipeline register and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            scnt_q  <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            scnt_q  <= scnt_d;
        end
    end

    assign id_pc_plus4 = pc_q;
    assign id_instr    = instr_q;
    assign id_valid    = valid_q;
    assign id_rs       = instr_q[25:21];
    assign id_rt       = instr_q[20:16];
endmodule

// File: tb/tb_id_fetch_control.sv
// tb_id_fetch_control: directed checks of fetch redirect, stalls, reset and target wrap
module tb_id_fetch_control;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc_plus4;
    logic [31:0] instr, rs_data, rt_data;
    logic        ex_mem_read, ex_reg_write;
    logic [4:0]  ex_write_reg;
    logic        en, branch_taken, jump, id_valid, id_bubble;
    logic [9:0]  branch_address, jump_address, id_pc_plus4;
    logic [31:0] id_instr;
    logic [4:0]  id_rs, id_rt;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] ADD1  = 32'h0022_1820;
    localparam logic [31:0] ADD3  = 32'h0064_2020;
    localparam logic [31:0] ADD5  = 32'h00A6_3820;
    localparam logic [31:0] JMP2  = 32'h0800_0002;
    localparam logic [31:0] BEQFD = 32'h1022_00FD;
    localparam logic [31:0] BNE3  = 32'h1423_0004;
    localparam logic [31:0] BEQ2  = 32'h1022_0002;

    id_fetch_control dut (
        .clk(clk), .reset(reset), .pc_plus4(pc_plus4), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg), .en(en),
        .branch_address(branch_address), .jump_address(jump_address),
        .branch_taken(branch_taken), .jump(jump), .id_pc_plus4(id_pc_plus4),
        .id_instr(id_instr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_bubble(id_bubble)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [9:0] pc, input logic [31:0] ins);
        pc_plus4 = pc;
        instr    = ins;
    endtask

    task automatic ex(input logic mr, input logic rw, input logic [4:0] wr);
        ex_mem_read  = mr;
        ex_reg_write = rw;
        ex_write_reg = wr;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        fetch(10'd0, 32'd0);
        rs_data = 32'd0;
        rt_data = 32'd0;
        ex(1'b0, 1'b0, 5'd0);
        tick();
        tick();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_en", {31'd0, en}, 32'd1);
        chk("rst_bubble", {31'd0, id_bubble}, 32'd0);
        chk("rst_jump", {31'd0, jump}, 32'd0);
        chk("rst_taken", {31'd0, branch_taken}, 32'd0);
        chk("rst_baddr", {22'd0, branch_address}, 32'd0);
        reset = 1'b1;
        fetch(10'd4, ADD1);
        tick();
        chk("seq4_pc", {22'd0, id_pc_plus4}, 32'd4);
        chk("seq4_valid", {31'd0, id_valid}, 32'd1);
        fetch(10'd8, ADD5);
        tick();
        chk("seq8_pc", {22'd0, id_pc_plus4}, 32'd8);
        chk("seq8_instr", id_instr, ADD5);
        fetch(10'd12, ADD1);
        tick();
        chk("seq12_pc", {22'd0, id_pc_plus4}, 32'd12);
        fetch(10'd16, JMP2);
        tick();
        fetch(10'd20, ADD1);
        #1;
        chk("j_jump", {31'd0, jump}, 32'd1);
        chk("j_addr", {22'd0, jump_address}, 32'd8);
        chk("j_en", {31'd0, en}, 32'd1);
        chk("j_taken", {31'd0, branch_taken}, 32'd0);
        tick();
        chk("j_sq_instr", id_instr, 32'd0);
        chk("j_sq_valid", {31'd0, id_valid}, 32'd0);
        chk("j_sq_pc", {22'd0, id_pc_plus4}, 32'd20);
        fetch(10'd16, BEQFD);
        tick();
        fetch(10'd20, ADD1);
        rs_data = 32'd5;
        rt_data = 32'd5;
        #1;
        chk("beq_taken", {31'd0, branch_taken}, 32'd1);
        chk("beq_addr", {22'd0, branch_address}, 32'd4);
        rt_data = 32'd6;
        #1;
        chk("beq_nt", {31'd0, branch_taken}, 32'd0);
        tick();
        chk("beq_nt_valid", {31'd0, id_valid}, 32'd1);
        chk("beq_nt_instr", id_instr, ADD1);
        fetch(10'd24, ADD3);
        tick();
        ex(1'b1, 1'b1, 5'd3);
        fetch(10'd28, ADD5);
        #1;
        chk("lu_en", {31'd0, en}, 32'd0);
        chk("lu_bubble", {31'd0, id_bubble}, 32'd1);
        tick();
        chk("lu_hold_pc", {22'd0, id_pc_plus4}, 32'd24);
        chk("lu_hold_instr", id_instr, ADD3);
        ex(1'b0, 1'b0, 5'd0);
        #1;
        chk("lu_en_after", {31'd0, en}, 32'd1);
        chk("lu_bub_after", {31'd0, id_bubble}, 32'd0);
        tick();
        chk("lu_adv_pc", {22'd0, id_pc_plus4}, 32'd28);
        fetch(10'd32, BNE3);
        tick();
        ex(1'b1, 1'b1, 5'd3);
        fetch(10'd36, ADD1);
        rs_data = 32'd7;
        rt_data = 32'd9;
        #1;
        chk("lb_en1", {31'd0, en}, 32'd0);
        chk("lb_taken1", {31'd0, branch_taken}, 32'd0);
        tick();
        ex(1'b0, 1'b0, 5'd0);
        #1;
        chk("lb_en2", {31'd0, en}, 32'd0);
        chk("lb_bub2", {31'd0, id_bubble}, 32'd1);
        chk("lb_hold_pc", {22'd0, id_pc_plus4}, 32'd32);
        tick();
        rt_data = 32'd8;
        #1;
        chk("lb_en3", {31'd0, en}, 32'd1);
        chk("lb_taken", {31'd0, branch_taken}, 32'd1);
        chk("lb_addr", {22'd0, branch_address}, 32'd48);
        tick();
        chk("lb_sq_valid", {31'd0, id_valid}, 32'd0);
        chk("lb_sq_pc", {22'd0, id_pc_plus4}, 32'd36);
        fetch(10'd40, BNE3);
        tick();
        ex(1'b1, 1'b1, 5'd0);
        rs_data = 32'd7;
        rt_data = 32'd7;
        fetch(10'd44, BNE3);
        #1;
        chk("r0_en", {31'd0, en}, 32'd1);
        chk("r0_bubble", {31'd0, id_bubble}, 32'd0);
        chk("r0_taken", {31'd0, branch_taken}, 32'd0);
        tick();
        chk("r0_adv_pc", {22'd0, id_pc_plus4}, 32'd44);
        ex(1'b1, 1'b1, 5'd3);
        #1;
        chk("rs_en1", {31'd0, en}, 32'd0);
        tick();
        chk("rs_en2", {31'd0, en}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rs_en_rst", {31'd0, en}, 32'd1);
        chk("rs_valid_rst", {31'd0, id_valid}, 32'd0);
        chk("rs_pc_rst", {22'd0, id_pc_plus4}, 32'd0);
        ex(1'b0, 1'b0, 5'd0);
        reset = 1'b1;
        #1;
        chk("rs_en_rel", {31'd0, en}, 32'd1);
        fetch(10'd48, ADD1);
        tick();
        chk("rs_load_pc", {22'd0, id_pc_plus4}, 32'd48);
        chk("rs_load_valid", {31'd0, id_valid}, 32'd1);
        fetch(10'd1020, BEQ2);
        tick();
        rs_data = 32'd1;
        rt_data = 32'd1;
        #1;
        chk("wrap_addr", {22'd0, branch_address}, 32'd4);
        chk("wrap_taken", {31'd0, branch_taken}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
